// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM encoding and default sizing.
package pulse_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_W           = 32;
  localparam logic [31:0] DEFAULT_TIMEOUT     = 32'hFFFF_FFFF;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_period_meter_sync_edge_det.sv
// Synchroniser chain for an asynchronous level plus registered one-cycle rise/fall strobes.
module sync_edge_det
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      lvl_p1  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // stage p0: metastability chain
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      // stage p1: previous synchronised level and edge strobes
      lvl_p1  <= sync_p0[SYNC_STAGES-1];
      rise    <= sync_p0[SYNC_STAGES-1] & ~lvl_p1;
      fall    <= ~sync_p0[SYNC_STAGES-1] & lvl_p1;
    end
  end

endmodule

// File: rtl/pulse_period_meter.sv
// Recovers period and high width (in clk cycles) of a pulse stream; results on valid/ack.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned    W           = DEFAULT_W,
  parameter logic [W-1:0]   TIMEOUT     = W'(DEFAULT_TIMEOUT),
  parameter int unsigned    SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         pulse_in,
  input  logic         meas_ack,
  output logic [W-1:0] period,
  output logic [W-1:0] high_width,
  output logic         meas_valid,
  output logic         overrun,
  output logic         timeout
);

  state_t       state, state_nxt;
  logic         rise, fall;
  logic [W-1:0] cnt, hw_reg;
  logic         to_hit;
  logic         pub_vld_p1;
  logic [W-1:0] pub_period_p1, pub_hw_p1;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pulse_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign to_hit = (cnt == TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable) state_nxt = ST_ARM;
      ST_ARM:     if (rise) state_nxt = ST_MEASURE;
      ST_MEASURE: if (!rise && to_hit) state_nxt = ST_ARM;
      default:    state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // stage p0: interval counter; a rise closes one period and opens the next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      hw_reg        <= '0;
      timeout       <= 1'b0;
      pub_vld_p1    <= 1'b0;
      pub_period_p1 <= '0;
      pub_hw_p1     <= '0;
    end else if (!enable) begin
      cnt        <= '0;
      hw_reg     <= '0;
      timeout    <= 1'b0;
      pub_vld_p1 <= 1'b0;
    end else begin
      pub_vld_p1 <= 1'b0;
      case (state)
        ST_ARM: begin
          if (rise) begin
            cnt     <= W'(1);
            timeout <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (fall) hw_reg <= cnt;
          if (rise) begin
            cnt           <= W'(1);
            timeout       <= 1'b0;
            pub_vld_p1    <= 1'b1;
            pub_period_p1 <= cnt;
            pub_hw_p1     <= hw_reg;
          end else if (to_hit) begin
            cnt     <= '0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // stage p1: result register and handshake; an unacked result is never overwritten
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period     <= '0;
      high_width <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (!enable) begin
      period     <= '0;
      high_width <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (pub_vld_p1) begin
      if (!meas_valid || meas_ack) begin
        period     <= pub_period_p1;
        high_width <= pub_hw_p1;
        meas_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (meas_ack) begin
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: stream table plus hand-timed corner sequences.
module tb_pulse_period_meter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pulse_a, ack_a, pulse_b, ack_b;
  logic [31:0] a_period, a_hw, b_period, b_hw;
  logic        a_valid, a_ovr, a_to, b_valid, b_ovr, b_to;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int per;
    int hi;
    int n;
    bit ack;
    int exp_p;
    int exp_h;
    bit exp_v;
    bit exp_o;
  } vec_t;

  vec_t vecs[6];

  pulse_period_meter #(.W(32)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_a), .meas_ack(ack_a),
    .period(a_period), .high_width(a_hw), .meas_valid(a_valid), .overrun(a_ovr),
    .timeout(a_to)
  );

  pulse_period_meter #(.W(32), .TIMEOUT(32'd50)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_b), .meas_ack(ack_b),
    .period(b_period), .high_width(b_hw), .meas_valid(b_valid), .overrun(b_ovr),
    .timeout(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Clears the meter via enable and confirms everything is cleared one cycle later.
  task automatic clear_and_enable();
    enable  = 1'b0;
    pulse_a = 1'b0;
    ack_a   = 1'b0;
    pulse_b = 1'b0;
    ack_b   = 1'b0;
    tick();
    check("clr_valid", 32'(a_valid), 32'd0);
    check("clr_overrun", 32'(a_ovr), 32'd0);
    check("clr_timeout", 32'(a_to), 32'd0);
    check("clr_period", a_period, 32'd0);
    repeat (3) tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic run_stream(input int per, input int hi, input int n, input bit ack_on,
                            input int exp_p, input int exp_h);
    for (int k = 0; k < n * per + 8; k++) begin
      if (ack_on && a_valid) begin
        check("stream_period", a_period, 32'(exp_p));
        check("stream_high", a_hw, 32'(exp_h));
        ack_a = 1'b1;
      end else begin
        ack_a = 1'b0;
      end
      pulse_a = (k < n * per) && ((k % per) < hi);
      tick();
    end
    ack_a   = 1'b0;
    pulse_a = 1'b0;
  endtask

  initial begin
    vecs[0] = '{per: 100, hi: 10, n: 4, ack: 1'b1, exp_p: 100, exp_h: 10, exp_v: 1'b0, exp_o: 1'b0};
    vecs[1] = '{per: 100, hi: 10, n: 3, ack: 1'b0, exp_p: 100, exp_h: 10, exp_v: 1'b1, exp_o: 1'b1};
    vecs[2] = '{per: 37,  hi: 1,  n: 4, ack: 1'b1, exp_p: 37,  exp_h: 1,  exp_v: 1'b0, exp_o: 1'b0};
    vecs[3] = '{per: 20,  hi: 19, n: 3, ack: 1'b0, exp_p: 20,  exp_h: 19, exp_v: 1'b1, exp_o: 1'b1};
    vecs[4] = '{per: 2,   hi: 1,  n: 5, ack: 1'b1, exp_p: 2,   exp_h: 1,  exp_v: 1'b0, exp_o: 1'b0};
    vecs[5] = '{per: 2,   hi: 1,  n: 3, ack: 1'b0, exp_p: 2,   exp_h: 1,  exp_v: 1'b1, exp_o: 1'b1};

    reset   = 1'b0;
    enable  = 1'b0;
    pulse_a = 1'b0;
    ack_a   = 1'b0;
    pulse_b = 1'b0;
    ack_b   = 1'b0;
    repeat (3) tick();
    check("rst_period", a_period, 32'd0);
    check("rst_high", a_hw, 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_overrun", 32'(a_ovr), 32'd0);
    check("rst_timeout", 32'(a_to), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      clear_and_enable();
      run_stream(vecs[i].per, vecs[i].hi, vecs[i].n, vecs[i].ack, vecs[i].exp_p, vecs[i].exp_h);
      check("vec_valid", 32'(a_valid), 32'(vecs[i].exp_v));
      check("vec_overrun", 32'(a_ovr), 32'(vecs[i].exp_o));
      check("vec_period", a_period, 32'(vecs[i].exp_p));
      check("vec_high", a_hw, 32'(vecs[i].exp_h));
      check("vec_timeout", 32'(a_to), 32'd0);
    end

    // ack lands exactly in the cycle the third rise publishes
    clear_and_enable();
    for (int k = 0; k <= 72; k++) begin
      if (k == 45) begin
        check("pubcyc_first_valid", 32'(a_valid), 32'd1);
        check("pubcyc_first_period", a_period, 32'd40);
        check("pubcyc_first_high", a_hw, 32'd8);
      end
      if (k == 69) begin
        check("pubcyc_pre_valid", 32'(a_valid), 32'd1);
        check("pubcyc_pre_period", a_period, 32'd40);
      end
      if (k == 70) begin
        check("pubcyc_valid", 32'(a_valid), 32'd1);
        check("pubcyc_period", a_period, 32'd25);
        check("pubcyc_high", a_hw, 32'd8);
        check("pubcyc_overrun", 32'(a_ovr), 32'd0);
      end
      pulse_a = (k < 8) || (k >= 40 && k < 48) || (k >= 65 && k < 73);
      ack_a   = (k == 69);
      tick();
    end
    pulse_a = 1'b0;
    ack_a   = 1'b0;

    // reset asserted while holding an unacked result with overrun set
    clear_and_enable();
    run_stream(30, 5, 3, 1'b0, 30, 5);
    check("prerst_valid", 32'(a_valid), 32'd1);
    check("prerst_overrun", 32'(a_ovr), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(a_valid), 32'd0);
    check("midrst_overrun", 32'(a_ovr), 32'd0);
    check("midrst_period", a_period, 32'd0);
    check("midrst_high", a_hw, 32'd0);
    check("midrst_timeout", 32'(a_to), 32'd0);
    tick();
    check("midrst_hold_valid", 32'(a_valid), 32'd0);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 70; k++) begin
      if (k == 30) check("postrst_one_rise_valid", 32'(a_valid), 32'd0);
      pulse_a = (k < 60) && ((k % 30) < 5);
      tick();
    end
    pulse_a = 1'b0;
    check("postrst_valid", 32'(a_valid), 32'd1);
    check("postrst_period", a_period, 32'd30);
    check("postrst_high", a_hw, 32'd5);

    // timeout on the TIMEOUT=50 instance: one rise, then silence
    clear_and_enable();
    check("to_init", 32'(b_to), 32'd0);
    for (int k = 0; k <= 100; k++) begin
      if (k == 53) check("to_before", 32'(b_to), 32'd0);
      if (k == 54) check("to_fire", 32'(b_to), 32'd1);
      if (k == 63) check("to_hold", 32'(b_to), 32'd1);
      if (k == 64) begin
        check("to_cleared", 32'(b_to), 32'd0);
        check("to_rearm_valid", 32'(b_valid), 32'd0);
      end
      if (k == 89) check("to_no_result", 32'(b_valid), 32'd0);
      pulse_b = (k < 5) || (k >= 60 && k < 65) || (k >= 90 && k < 95);
      tick();
    end
    pulse_b = 1'b0;
    check("to_after_valid", 32'(b_valid), 32'd1);
    check("to_after_period", b_period, 32'd30);
    check("to_after_high", b_hw, 32'd5);
    check("to_after_overrun", 32'(b_ovr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
